ram_dp_be: RTL and testbench
============================

Name: ram_dp_be

Overview:
- Parametrised successor to the single-port RAM: simple dual-port memory with one write port and one read port.
- Write port has per-byte write masking; read port has 1-cycle registered latency and a ReadValid strobe.
- Includes write-first collision bypass and a post-reset zero-fill sequencer with a Ready flag.
- Sits as the generic on-chip storage block for register files, FIFOs and scratch buffers.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8: address width; DEPTH = 2**ADDR_WIDTH words.
- LANES, DATA_WIDTH/8: derived byte-lane count; not overridable.

Ports:
- Clk  in  1  clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Ready  out  1  high once zero-fill is complete; accesses accepted only while high
- WriteEn  in  1  write request
- WriteAddr  in  ADDR_WIDTH  write address
- WriteMask  in  LANES  per-byte write enable; bit i covers WriteData[8i+7:8i]
- WriteData  in  DATA_WIDTH  write data
- ReadEn  in  1  read request
- ReadAddr  in  ADDR_WIDTH  read address
- ReadData  out  DATA_WIDTH  registered read data
- ReadValid  out  1  ReadData valid this cycle

Behaviour:
- Reset is sampled at the rising edge. On reset:
  - state=INIT, fill counter=0
  - Ready=0, ReadValid=0, ReadData=0
- INIT state:
  - Each cycle writes 0 to mem[counter], then counter+1.
  - After writing address DEPTH-1, moves to RUN; Ready=1 from the next cycle.
  - Ready therefore rises exactly DEPTH cycles after Reset deasserts.
  - WriteEn and ReadEn are ignored; ReadValid stays 0.
- RUN state: remains in RUN until Reset.
- Write: on edge with WriteEn&&Ready, each lane i with WriteMask[i]=1 updates mem[WriteAddr] lane i. Unmasked lanes are unchanged. WriteMask=0 means no change.
- Read:
  - ReadEn&&Ready sampled at edge k gives ReadData=mem[ReadAddr] and ReadValid=1 after edge k+1.
  - ReadValid pulses exactly one cycle per accepted read.
  - Back-to-back reads give one result per cycle.
  - ReadData holds its last value while ReadValid=0.
- Collision (read and write at the same address, same edge):
  - Write-first, per lane.
  - Masked lanes return WriteData; unmasked lanes return the old contents.
- Different addresses in the same cycle are fully independent.
- Addresses are exactly ADDR_WIDTH bits; no out-of-range case exists.
- Reset mid-INIT restarts the fill at address 0. Reset in RUN drops Ready and re-clears the whole memory. A read in flight when Reset asserts produces no ReadValid.

Optional Feature:
- RAM_OUT_REG_EN defined:
  - Adds an output register stage; read latency becomes 2 cycles.
  - ReadValid is delayed in step with the data.
  - Collision bypass is still taken at the first stage.
  - Reset clears both stages.
- Undefined: latency is 1 cycle as above.

Decomposition:
- Package ram_pkg:
  - state enum {RAM_INIT, RAM_RUN}
  - BYTE_W=8 constant
  - depth function 2**ADDR_WIDTH
  - lane-mask merge function (old, new, mask) -> word
- Sub-module ram_lane: one 8-bit-wide DEPTH-deep array with its own write enable and read port. It is instantiated LANES times via generate. The top level holds the fill sequencer, bypass and output registers.

Test Plan (DATA_WIDTH=32, ADDR_WIDTH=8):
- Reset 1 cycle, then release → Ready=0 for 256 cycles, then 1. Read 0x05 → ReadData=0x00000000, ReadValid high 1 cycle.
- Write 0x10=0xDEADBEEF mask 4'b1111; read 0x10 next cycle → 0xDEADBEEF exactly 1 cycle after ReadEn.
- Then write 0x10=0x11223344 mask 4'b0101; read → 0xDE22BE44. Write with mask 4'b0000 → still 0xDE22BE44.
- Same edge: write 0x20=0xCAFEF00D mask 4'b0011 over 0xAABBCCDD, and read 0x20 → ReadData=0xAABBF00D.
- Write i*3 to addresses 0..255; then 256 back-to-back reads → each returns (i*3)&0xFFFFFFFF. ReadValid stays high for 256 consecutive cycles.
- Assert Reset after fill cycle 100; ReadEn during INIT → no ReadValid. After Ready, read 0x10 → 0x00000000. Repeat with RAM_OUT_REG_EN → latency 2 cycles, same data.

Source files
------------

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types, constants and helpers for the dual-port byte-enable RAM
package ram_pkg;

    typedef enum logic {
        RAM_INIT = 1'b0,
        RAM_RUN  = 1'b1
    } ram_state_t;

    localparam int BYTE_W = 8;

    // Upper bound on word width handled by lane_merge; callers size-cast
    // their words up to MAX_W and slice the result back down.
    localparam int MAX_W     = 256;
    localparam int MAX_LANES = MAX_W / BYTE_W;

    function automatic int depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Lanes with mask=1 take new_word, others keep old_word.
    function automatic logic [MAX_W-1:0] lane_merge(
        input logic [MAX_W-1:0]     old_word,
        input logic [MAX_W-1:0]     new_word,
        input logic [MAX_LANES-1:0] mask
    );
        logic [MAX_W-1:0] w;
        w = old_word;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (mask[i]) begin
                w[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/ram_lane.sv
// rtl/ram_lane.sv - one byte-wide storage lane with a write port and a registered read port
//
// Ports: clk, rst (sync, active-high, clears only the read register),
//        we/waddr/wdata write port, re/raddr read request, rdata registered read data.
// On a same-edge read and write of one address the read returns the old byte;
// the top level applies write-first bypass on top of that.
module ram_lane
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [BYTE_W-1:0]     wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [BYTE_W-1:0]     rdata
);

    localparam int DEPTH = depth(ADDR_WIDTH);

    logic [BYTE_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_dp_be.sv
// rtl/ram_dp_be.sv - simple dual-port RAM with per-byte write mask, write-first bypass and zero-fill
//
// Ports: Clk, Reset (sync, active-high), Ready (zero-fill done, accesses accepted),
//        WriteEn/WriteAddr/WriteMask/WriteData write port,
//        ReadEn/ReadAddr read request, ReadData/ReadValid read result.
// Optional macro RAM_OUT_REG_EN adds a second output register (read latency 2).
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                             Clk,
    input  logic                             Reset,
    output logic                             Ready,
    input  logic                             WriteEn,
    input  logic [ADDR_WIDTH-1:0]            WriteAddr,
    input  logic [DATA_WIDTH/BYTE_W-1:0]     WriteMask,
    input  logic [DATA_WIDTH-1:0]            WriteData,
    input  logic                             ReadEn,
    input  logic [ADDR_WIDTH-1:0]            ReadAddr,
    output logic [DATA_WIDTH-1:0]            ReadData,
    output logic                             ReadValid
);

    localparam int LANES = DATA_WIDTH / BYTE_W;
    localparam int DEPTH = depth(ADDR_WIDTH);

    ram_state_t            state;
    ram_state_t            state_next;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic                  fill_active;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= RAM_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: leave INIT right after the last address is cleared
    always_comb begin
        state_next = state;
        if (state == RAM_INIT && fill_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state_next = RAM_RUN;
        end
    end

    // Output decode
    always_comb begin
        Ready       = 1'b0;
        fill_active = 1'b0;
        case (state)
            RAM_INIT: fill_active = 1'b1;
            RAM_RUN:  Ready       = 1'b1;
            default:  fill_active = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fill_cnt <= '0;
        end else if (fill_active) begin
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    logic wr_acc;
    logic rd_acc;

    assign wr_acc = WriteEn && Ready;
    assign rd_acc = ReadEn && Ready && !Reset;

    logic [ADDR_WIDTH-1:0] lane_waddr;
    logic [DATA_WIDTH-1:0] lane_rdata;

    assign lane_waddr = fill_active ? fill_cnt : WriteAddr;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic lane_we;
        logic [BYTE_W-1:0] lane_wdata;

        assign lane_we    = fill_active || (wr_acc && WriteMask[i]);
        assign lane_wdata = fill_active ? '0 : WriteData[i*BYTE_W +: BYTE_W];

        ram_lane #(
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_lane (
            .clk   (Clk),
            .rst   (Reset),
            .we    (lane_we),
            .waddr (lane_waddr),
            .wdata (lane_wdata),
            .re    (rd_acc),
            .raddr (ReadAddr),
            .rdata (lane_rdata[i*BYTE_W +: BYTE_W])
        );
    end

    // The lanes return pre-write bytes on a collision, so the lanes being
    // written in the same edge are remembered and overlaid after the read.
    logic [LANES-1:0]      byp_mask_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic                  valid1_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            byp_mask_q <= '0;
            byp_data_q <= '0;
            valid1_q   <= 1'b0;
        end else begin
            valid1_q <= rd_acc;
            if (rd_acc) begin
                byp_mask_q <= (wr_acc && WriteAddr == ReadAddr) ? WriteMask : '0;
                byp_data_q <= WriteData;
            end
        end
    end

    logic [MAX_W-1:0]      merged_wide;
    logic [DATA_WIDTH-1:0] stage1_data;

    assign merged_wide = lane_merge(MAX_W'(lane_rdata), MAX_W'(byp_data_q), MAX_LANES'(byp_mask_q));
    assign stage1_data = merged_wide[DATA_WIDTH-1:0];

    logic unused_merge_hi;
    assign unused_merge_hi = ^merged_wide[MAX_W-1:DATA_WIDTH];

`ifdef RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] data2_q;
    logic                  valid2_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            data2_q  <= '0;
            valid2_q <= 1'b0;
        end else begin
            valid2_q <= valid1_q;
            if (valid1_q) begin
                data2_q <= stage1_data;
            end
        end
    end

    assign ReadData  = data2_q;
    assign ReadValid = valid2_q;
`else
    assign ReadData  = stage1_data;
    assign ReadValid = valid1_q;
`endif

endmodule

// File: tb/tb_ram_dp_be.sv
// tb/tb_ram_dp_be.sv - scoreboard testbench for ram_dp_be
module tb_ram_dp_be;

    localparam int DW = 32;
    localparam int AW = 8;
`ifdef RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          Clk;
    logic          Reset;
    logic          Ready;
    logic          WriteEn;
    logic [AW-1:0] WriteAddr;
    logic [3:0]    WriteMask;
    logic [DW-1:0] WriteData;
    logic          ReadEn;
    logic [AW-1:0] ReadAddr;
    logic [DW-1:0] ReadData;
    logic          ReadValid;

    ram_dp_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Ready     (Ready),
        .WriteEn   (WriteEn),
        .WriteAddr (WriteAddr),
        .WriteMask (WriteMask),
        .WriteData (WriteData),
        .ReadEn    (ReadEn),
        .ReadAddr  (ReadAddr),
        .ReadData  (ReadData),
        .ReadValid (ReadValid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   ncyc    = 0;
    int   run     = 0;
    int   max_run = 0;

    // Monitor: pops one expectation per ReadValid cycle
    always @(negedge Clk) begin
        exp_t e;
        ncyc = ncyc + 1;
        if (ReadValid === 1'b1) begin
            run = run + 1;
            if (run > max_run) max_run = run;
            n_cmp = n_cmp + 1;
            if (sb.size() == 0) begin
                n_bad = n_bad + 1;
                $display("FAIL unexpected_valid: ReadValid=1 ReadData=%h with nothing outstanding (cycle %0d)", ReadData, ncyc);
            end else begin
                e = sb.pop_front();
                if (ReadData !== e.d) begin
                    n_bad = n_bad + 1;
                    $display("FAIL read_data: got %h expected %h (cycle %0d)", ReadData, e.d, ncyc);
                end
                n_cmp = n_cmp + 1;
                if (ncyc != e.due) begin
                    n_bad = n_bad + 1;
                    $display("FAIL read_latency: valid at cycle %0d expected %0d", ncyc, e.due);
                end
            end
        end else begin
            run = 0;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are set just after a rising edge; they are sampled at the next
    // edge and the result is visible LAT negedges after that.
    task automatic push_exp(input logic [DW-1:0] d);
        exp_t e;
        e.d   = d;
        e.due = ncyc + 1 + LAT;
        sb.push_back(e);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
        WriteEn   = 1'b1;
        WriteAddr = a;
        WriteData = d;
        WriteMask = m;
        step();
        WriteEn = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        ReadEn   = 1'b1;
        ReadAddr = a;
        push_exp(exp);
        step();
        ReadEn = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            step();
            t++;
        end
        step();
        n_cmp = n_cmp + 1;
        if (sb.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain_timeout: %0d reads still outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Releases Reset and counts cycles until Ready; ReadEn/WriteEn are held
    // high for the first hold cycles to show they are ignored during fill.
    task automatic release_and_wait(input int hold);
        int n;
        Reset = 1'b0;
        n = 0;
        while (Ready !== 1'b1 && n < 1000) begin
            if (n == hold) begin
                ReadEn  = 1'b0;
                WriteEn = 1'b0;
            end
            step();
            n++;
        end
        ReadEn  = 1'b0;
        WriteEn = 1'b0;
        check("ready_rise_cycles", DW'(n), DW'(256));
    endtask

    initial begin
        Reset     = 1'b1;
        WriteEn   = 1'b0;
        WriteAddr = '0;
        WriteMask = '0;
        WriteData = '0;
        ReadEn    = 1'b0;
        ReadAddr  = '0;
        step();
        check("reset_ready", DW'(Ready), 0);
        check("reset_valid", DW'(ReadValid), 0);
        check("reset_data", ReadData, 0);
        release_and_wait(0);

        do_read(8'h05, 32'h0000_0000);
        drain();

        do_write(8'h10, 32'hDEAD_BEEF, 4'b1111);
        do_read(8'h10, 32'hDEAD_BEEF);
        drain();
        step();
        check("hold_valid_low", DW'(ReadValid), 0);
        check("hold_data", ReadData, 32'hDEAD_BEEF);

        do_write(8'h10, 32'h1122_3344, 4'b0101);
        do_read(8'h10, 32'hDE22_BE44);
        do_write(8'h10, 32'h5566_7788, 4'b0000);
        do_read(8'h10, 32'hDE22_BE44);
        drain();

        // Same-edge collision, write-first per lane
        do_write(8'h20, 32'hAABB_CCDD, 4'b1111);
        WriteEn   = 1'b1;
        WriteAddr = 8'h20;
        WriteData = 32'hCAFE_F00D;
        WriteMask = 4'b0011;
        ReadEn    = 1'b1;
        ReadAddr  = 8'h20;
        push_exp(32'hAABB_F00D);
        step();
        WriteEn = 1'b0;
        ReadEn  = 1'b0;
        do_read(8'h20, 32'hAABB_F00D);

        // Different addresses in the same edge stay independent
        WriteEn   = 1'b1;
        WriteAddr = 8'h21;
        WriteData = 32'h0BAD_CAFE;
        WriteMask = 4'b1111;
        ReadEn    = 1'b1;
        ReadAddr  = 8'h10;
        push_exp(32'hDE22_BE44);
        step();
        WriteEn = 1'b0;
        ReadEn  = 1'b0;
        do_read(8'h21, 32'h0BAD_CAFE);
        drain();

        for (int i = 0; i < 256; i++) begin
            do_write(AW'(i), DW'(i * 3), 4'b1111);
        end
        max_run = 0;
        ReadEn  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ReadAddr = AW'(i);
            push_exp(DW'(i * 3));
            step();
        end
        ReadEn = 1'b0;
        drain();
        check("back_to_back_run", DW'(max_run), DW'(256));

        // Read requested on the reset edge must never produce ReadValid
        ReadEn   = 1'b1;
        ReadAddr = 8'h10;
        Reset    = 1'b1;
        step();
        Reset = 1'b0;
        ReadEn = 1'b0;
        for (int i = 0; i < 100; i++) step();

        // Reset mid-fill, with reads and writes requested during INIT
        Reset = 1'b1;
        step();
        ReadEn    = 1'b1;
        ReadAddr  = 8'h10;
        WriteEn   = 1'b1;
        WriteAddr = 8'h10;
        WriteData = 32'hFFFF_FFFF;
        WriteMask = 4'b1111;
        release_and_wait(200);

        do_read(8'h10, 32'h0000_0000);
        do_read(8'h21, 32'h0000_0000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
